// File: rtl/exp_series_pkg.sv
// Shared types and constants for the Q8.8 exp(x) series controller.
// Optional build macro: EXP_SERIES_ALT_SIGN_EN (alternating-sign series, exp(-x)).
package exp_series_pkg;

    localparam int          MAX_TERMS_DEF = 15;
    localparam logic [15:0] ONE           = 16'h0100;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_MUL_X = 3'd2,
        S_MUL_C = 3'd3,
        S_CHECK = 3'd4,
        S_ADD   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/exp_series_ctrl_counter.sv
// Coefficient index counter: clear, saturating increment, terminal count at MAX_TERMS-1.
module exp_term_counter #(
    parameter int MAX_TERMS = 15,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [IDX_W-1:0] index,
    output logic             tc
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(MAX_TERMS - 1);

    assign tc = (index == LAST);

    // Never steps past LAST, so the coefficient ROM only sees valid addresses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            index <= '0;
        else if (clear)
            index <= '0;
        else if (inc && !tc)
            index <= index + IDX_W'(1);
    end

endmodule

// File: rtl/exp_series_ctrl.sv
// Control FSM for the Q8.8 exp series datapath with start/ready/done handshake.
// EXP_SERIES_ALT_SIGN_EN: subtract odd-power terms so the datapath computes exp(-x).
module exp_series_ctrl
    import exp_series_pkg::*;
#(
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             less,
    output logic             ready,
    output logic             done,
    output logic             ld_x,
    output logic             ld_y,
    output logic             iz_term,
    output logic             iz_ans,
    output logic             ld_term,
    output logic             mux_sel,
    output logic             ld_ans,
    output logic             neg,
    output logic [IDX_W-1:0] index
);

    state_t state;
    logic   tc;
    logic   add_neg;

    exp_term_counter #(
        .MAX_TERMS(MAX_TERMS),
        .IDX_W    (IDX_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clear(state == S_INIT),
        .inc  (state == S_ADD),
        .index(index),
        .tc   (tc)
    );

    // Bus capture happens on the accepting edge itself.
    assign ld_x = ready & start;
    assign ld_y = ready & start;

`ifdef EXP_SERIES_ALT_SIGN_EN
    assign add_neg = ~index[0];
`else
    assign add_neg = 1'b0;
`endif

    // Outputs are registered from the next state, so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            iz_term <= 1'b0;
            iz_ans  <= 1'b0;
            ld_term <= 1'b0;
            mux_sel <= 1'b0;
            ld_ans  <= 1'b0;
            neg     <= 1'b0;
        end else begin
            ready   <= 1'b0;
            done    <= 1'b0;
            iz_term <= 1'b0;
            iz_ans  <= 1'b0;
            ld_term <= 1'b0;
            mux_sel <= 1'b0;
            ld_ans  <= 1'b0;
            neg     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_INIT;
                        iz_term <= 1'b1;
                        iz_ans  <= 1'b1;
                    end else begin
                        ready   <= 1'b1;
                    end
                end
                S_INIT: begin
                    state   <= S_MUL_X;
                    ld_term <= 1'b1;
                end
                S_MUL_X: begin
                    state   <= S_MUL_C;
                    ld_term <= 1'b1;
                    mux_sel <= 1'b1;
                end
                S_MUL_C: state <= S_CHECK;
                S_CHECK: begin
                    if (less) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state  <= S_ADD;
                        ld_ans <= 1'b1;
                        neg    <= add_neg;
                    end
                end
                S_ADD: begin
                    if (tc) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state   <= S_MUL_X;
                        ld_term <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
